// File: rtl/xor_checksum_if.sv
// ---------------------------------------------------------------------------
// xor_checksum_if
// Handshake bundle between a word source, the xor_checksum engine and the
// result consumer.
//   in_data/in_valid/in_last/in_abort : word stream from the source
//   in_ready                          : engine can take a beat
//   out_sum/out_parity/out_count/out_sat/out_valid : frame result
//   out_ready                         : consumer takes the result
// Modports:
//   slave  - the checksum engine's view
//   master - the source/consumer side (testbench or surrounding logic)
// ---------------------------------------------------------------------------
interface xor_checksum_if #(
    parameter int WIDTH   = 16,
    parameter int COUNT_W = 8
);
    logic [WIDTH-1:0]   in_data;
    logic               in_valid;
    logic               in_last;
    logic               in_abort;
    logic               in_ready;
    logic [WIDTH-1:0]   out_sum;
    logic               out_parity;
    logic [COUNT_W-1:0] out_count;
    logic               out_sat;
    logic               out_valid;
    logic               out_ready;

    modport slave (
        input  in_data, in_valid, in_last, in_abort, out_ready,
        output in_ready, out_sum, out_parity, out_count, out_sat, out_valid
    );

    modport master (
        output in_data, in_valid, in_last, in_abort, out_ready,
        input  in_ready, out_sum, out_parity, out_count, out_sat, out_valid
    );
endinterface

// File: rtl/xor_checksum.sv
// ---------------------------------------------------------------------------
// xor_checksum
// Streaming XOR checksum engine. Folds every accepted WIDTH-bit word of a
// frame into an accumulator seeded with INIT, and on the last beat presents
// the checksum, its parity and a saturating beat count until the consumer
// takes it.
// Ports:
//   clk   - system clock, rising edge
//   reset - synchronous active-high reset
//   bus   - xor_checksum_if.slave (input stream, result, handshakes)
// Parameters:
//   WIDTH   - word / checksum width
//   INIT    - accumulator seed at reset and at each frame start
//   COUNT_W - beat counter width
// ---------------------------------------------------------------------------
module xor_checksum #(
    parameter int               WIDTH   = 16,
    parameter logic [WIDTH-1:0] INIT    = '0,
    parameter int               COUNT_W = 8
) (
    input  logic           clk,
    input  logic           reset,
    xor_checksum_if.slave  bus
);

    typedef enum logic [0:0] {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    state_t             r_state,       w_state_next;
    logic [WIDTH-1:0]   r_acc,         w_acc_next;
    logic [COUNT_W-1:0] r_cnt,         w_cnt_next;
    logic               r_sat,         w_sat_next;
    logic [WIDTH-1:0]   r_out_sum,     w_out_sum_next;
    logic               r_out_parity,  w_out_parity_next;
    logic [COUNT_W-1:0] r_out_count,   w_out_count_next;
    logic               r_out_sat,     w_out_sat_next;
    logic               r_out_valid,   w_out_valid_next;

    logic [WIDTH-1:0]   w_fold;
    logic [WIDTH-1:0]   w_par_chain;
    logic               w_fold_parity;
    logic               w_cnt_at_max;
    logic [COUNT_W-1:0] w_cnt_inc;
    logic               w_in_ready;
    logic               w_beat;

    // Per-bit fold of the incoming word into the accumulator (no carries).
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_fold
        assign w_fold[gi] = r_acc[gi] ^ bus.in_data[gi];
    end

    // Running parity across the folded word; the top tap is the result parity.
    assign w_par_chain[0] = w_fold[0];
    for (genvar gi = 1; gi < WIDTH; gi++) begin : g_parity
        assign w_par_chain[gi] = w_par_chain[gi-1] ^ w_fold[gi];
    end
    assign w_fold_parity = w_par_chain[WIDTH-1];

    // Counter sticks at all-ones; a beat arriving there marks saturation.
    assign w_cnt_at_max = &r_cnt;
    assign w_cnt_inc    = w_cnt_at_max ? r_cnt : r_cnt + COUNT_W'(1);

    // Ready depends only on state and reset, never on the input stream.
    assign w_in_ready = (r_state == ST_ACCUM) && !reset;
    assign w_beat     = bus.in_valid && w_in_ready;

    always_comb begin
        w_state_next      = r_state;
        w_acc_next        = r_acc;
        w_cnt_next        = r_cnt;
        w_sat_next        = r_sat;
        w_out_sum_next    = r_out_sum;
        w_out_parity_next = r_out_parity;
        w_out_count_next  = r_out_count;
        w_out_sat_next    = r_out_sat;
        w_out_valid_next  = r_out_valid;

        case (r_state)
            ST_ACCUM: begin
                if (bus.in_abort) begin
                    // Abort wins over last and does not need in_valid.
                    w_acc_next = INIT;
                    w_cnt_next = '0;
                    w_sat_next = 1'b0;
                end else if (w_beat) begin
                    if (bus.in_last) begin
                        w_out_sum_next    = w_fold;
                        w_out_parity_next = w_fold_parity;
                        w_out_count_next  = w_cnt_inc;
                        w_out_sat_next    = r_sat | w_cnt_at_max;
                        w_out_valid_next  = 1'b1;
                        w_state_next      = ST_HOLD;
                        w_acc_next        = INIT;
                        w_cnt_next        = '0;
                        w_sat_next        = 1'b0;
                    end else begin
                        w_acc_next = w_fold;
                        w_cnt_next = w_cnt_inc;
                        w_sat_next = r_sat | w_cnt_at_max;
                    end
                end
            end
            ST_HOLD: begin
                if (bus.out_ready) begin
                    w_out_valid_next = 1'b0;
                    w_state_next     = ST_ACCUM;
                end
            end
            default: begin
                w_state_next = ST_ACCUM;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_ACCUM;
            r_acc        <= INIT;
            r_cnt        <= '0;
            r_sat        <= 1'b0;
            r_out_sum    <= INIT;
            r_out_parity <= ^INIT;
            r_out_count  <= '0;
            r_out_sat    <= 1'b0;
            r_out_valid  <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_acc        <= w_acc_next;
            r_cnt        <= w_cnt_next;
            r_sat        <= w_sat_next;
            r_out_sum    <= w_out_sum_next;
            r_out_parity <= w_out_parity_next;
            r_out_count  <= w_out_count_next;
            r_out_sat    <= w_out_sat_next;
            r_out_valid  <= w_out_valid_next;
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.out_sum    = r_out_sum;
    assign bus.out_parity = r_out_parity;
    assign bus.out_count  = r_out_count;
    assign bus.out_sat    = r_out_sat;
    assign bus.out_valid  = r_out_valid;

endmodule

// File: tb/tb_xor_checksum.sv
// ---------------------------------------------------------------------------
// tb_xor_checksum
// Three engines share one stimulus stream:
//   a: WIDTH=16, INIT=0x0000, COUNT_W=8
//   b: WIDTH=16, INIT=0xFFFF, COUNT_W=8
//   c: WIDTH=16, INIT=0x0000, COUNT_W=2  (saturation)
// Handshake timing does not depend on data, so all three move in lockstep.
// Expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_xor_checksum;

    logic        clk;
    logic        reset;
    logic [15:0] drv_data;
    logic        drv_valid;
    logic        drv_last;
    logic        drv_abort;
    logic        drv_ready;

    int tests_run;
    int tests_failed;

    xor_checksum_if #(.WIDTH(16), .COUNT_W(8)) if_a ();
    xor_checksum_if #(.WIDTH(16), .COUNT_W(8)) if_b ();
    xor_checksum_if #(.WIDTH(16), .COUNT_W(2)) if_c ();

    assign if_a.in_data  = drv_data;
    assign if_a.in_valid = drv_valid;
    assign if_a.in_last  = drv_last;
    assign if_a.in_abort = drv_abort;
    assign if_a.out_ready = drv_ready;
    assign if_b.in_data  = drv_data;
    assign if_b.in_valid = drv_valid;
    assign if_b.in_last  = drv_last;
    assign if_b.in_abort = drv_abort;
    assign if_b.out_ready = drv_ready;
    assign if_c.in_data  = drv_data;
    assign if_c.in_valid = drv_valid;
    assign if_c.in_last  = drv_last;
    assign if_c.in_abort = drv_abort;
    assign if_c.out_ready = drv_ready;

    xor_checksum #(.WIDTH(16), .INIT(16'h0000), .COUNT_W(8)) u_dut_a (
        .clk(clk), .reset(reset), .bus(if_a)
    );
    xor_checksum #(.WIDTH(16), .INIT(16'hFFFF), .COUNT_W(8)) u_dut_b (
        .clk(clk), .reset(reset), .bus(if_b)
    );
    xor_checksum #(.WIDTH(16), .INIT(16'h0000), .COUNT_W(2)) u_dut_c (
        .clk(clk), .reset(reset), .bus(if_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One beat offered for exactly one edge, then the stream goes idle.
    task automatic send(input logic [15:0] d, input logic last, input logic abort);
        drv_data  = d;
        drv_valid = 1'b1;
        drv_last  = last;
        drv_abort = abort;
        tick();
        drv_valid = 1'b0;
        drv_last  = 1'b0;
        drv_abort = 1'b0;
    endtask

    // Result check for all three engines. Parity is shared: INIT=0xFFFF has
    // even parity, so engine b's parity equals engine a's.
    task automatic res(input string tag, input logic [15:0] sum_a, input logic [15:0] sum_b,
                       input logic par, input logic [7:0] cnt, input logic [1:0] cnt_c,
                       input logic sat_c);
        chk({tag, ".valid"},  if_a.out_valid,  1'b1);
        chk({tag, ".rdy"},    if_a.in_ready,   1'b0);
        chk({tag, ".sum_a"},  if_a.out_sum,    sum_a);
        chk({tag, ".sum_b"},  if_b.out_sum,    sum_b);
        chk({tag, ".sum_c"},  if_c.out_sum,    sum_a);
        chk({tag, ".par_a"},  if_a.out_parity, par);
        chk({tag, ".par_b"},  if_b.out_parity, par);
        chk({tag, ".cnt_a"},  if_a.out_count,  cnt);
        chk({tag, ".cnt_b"},  if_b.out_count,  cnt);
        chk({tag, ".cnt_c"},  if_c.out_count,  cnt_c);
        chk({tag, ".sat_a"},  if_a.out_sat,    1'b0);
        chk({tag, ".sat_c"},  if_c.out_sat,    sat_c);
    endtask

    task automatic rst_state(input string tag);
        chk({tag, ".valid_a"}, if_a.out_valid,  1'b0);
        chk({tag, ".valid_c"}, if_c.out_valid,  1'b0);
        chk({tag, ".sum_a"},   if_a.out_sum,    16'h0000);
        chk({tag, ".sum_b"},   if_b.out_sum,    16'hFFFF);
        chk({tag, ".par_b"},   if_b.out_parity, 1'b0);
        chk({tag, ".cnt_a"},   if_a.out_count,  8'd0);
        chk({tag, ".cnt_c"},   if_c.out_count,  2'd0);
        chk({tag, ".sat_c"},   if_c.out_sat,    1'b0);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset     = 1'b1;
        drv_data  = '0;
        drv_valid = 1'b0;
        drv_last  = 1'b0;
        drv_abort = 1'b0;
        drv_ready = 1'b1;

        // Reset state
        tick();
        tick();
        chk("rst.rdy", if_a.in_ready, 1'b0);
        rst_state("rst");
        reset = 1'b0;
        #1;
        chk("rst.rdy_after", if_a.in_ready, 1'b1);

        // Three-beat frame: 1234^00FF=12CB, 12CB^F0F0=E23B (9 ones -> parity 1)
        send(16'h1234, 1'b0, 1'b0);
        send(16'h00FF, 1'b0, 1'b0);
        send(16'hF0F0, 1'b1, 1'b0);
        res("t1", 16'hE23B, 16'h1DC4, 1'b1, 8'd3, 2'd3, 1'b0);
        tick();
        chk("t1.valid_drop", if_a.out_valid, 1'b0);
        chk("t1.rdy_back",   if_a.in_ready,  1'b1);

        // Single-beat frame
        send(16'h00FF, 1'b1, 1'b0);
        res("t2", 16'h00FF, 16'hFF00, 1'b0, 8'd1, 2'd1, 1'b0);
        tick();

        // Back-pressure: result held 5 cycles, offered beats ignored
        drv_ready = 1'b0;
        send(16'h1111, 1'b0, 1'b0);
        send(16'h2222, 1'b1, 1'b0);
        res("t3", 16'h3333, 16'hCCCC, 1'b0, 8'd2, 2'd2, 1'b0);
        for (int i = 0; i < 5; i++) begin
            drv_data  = 16'hBEEF;
            drv_valid = 1'b1;
            drv_last  = 1'b1;
            drv_abort = (i == 2);
            tick();
            chk($sformatf("t3.hold%0d.rdy", i),   if_a.in_ready,  1'b0);
            chk($sformatf("t3.hold%0d.valid", i), if_a.out_valid, 1'b1);
            chk($sformatf("t3.hold%0d.sum", i),   if_a.out_sum,   16'h3333);
            chk($sformatf("t3.hold%0d.cnt", i),   if_a.out_count, 8'd2);
        end
        drv_valid = 1'b0;
        drv_last  = 1'b0;
        drv_abort = 1'b0;
        drv_ready = 1'b1;
        tick();
        chk("t3.release", if_a.out_valid, 1'b0);
        send(16'h0003, 1'b1, 1'b0);
        res("t3.next", 16'h0003, 16'hFFFC, 1'b0, 8'd1, 2'd1, 1'b0);
        tick();

        // Abort beat carrying in_last: no result, next frame from INIT
        send(16'hAAAA, 1'b0, 1'b0);
        send(16'h5555, 1'b0, 1'b0);
        send(16'h1111, 1'b1, 1'b1);
        chk("t4.no_valid", if_a.out_valid, 1'b0);
        chk("t4.rdy",      if_a.in_ready,  1'b1);
        send(16'h0001, 1'b1, 1'b0);
        res("t4", 16'h0001, 16'hFFFE, 1'b1, 8'd1, 2'd1, 1'b0);
        tick();

        // Abort without in_valid
        send(16'h0F00, 1'b0, 1'b0);
        drv_abort = 1'b1;
        tick();
        drv_abort = 1'b0;
        send(16'h0002, 1'b1, 1'b0);
        res("t4b", 16'h0002, 16'hFFFD, 1'b1, 8'd1, 2'd1, 1'b0);
        tick();

        // Five beats: engine c saturates at 3 and flags it
        for (int i = 0; i < 4; i++) send(16'h0001, 1'b0, 1'b0);
        send(16'h0001, 1'b1, 1'b0);
        res("t5", 16'h0001, 16'hFFFE, 1'b1, 8'd5, 2'd3, 1'b1);
        tick();

        // Reset during a partial frame
        send(16'h00F0, 1'b0, 1'b0);
        send(16'h0F00, 1'b0, 1'b0);
        reset = 1'b1;
        #1;
        chk("t6.rdy_in_rst", if_a.in_ready, 1'b0);
        tick();
        rst_state("t6.mid");
        reset = 1'b0;
        send(16'h0005, 1'b1, 1'b0);
        res("t6.after", 16'h0005, 16'hFFFA, 1'b0, 8'd1, 2'd1, 1'b0);
        tick();

        // Reset during HOLD
        drv_ready = 1'b0;
        send(16'h0007, 1'b1, 1'b0);
        chk("t6.hold_valid", if_a.out_valid, 1'b1);
        reset = 1'b1;
        tick();
        rst_state("t6.hold");
        chk("t6.hold_rdy", if_a.in_ready, 1'b0);
        reset = 1'b0;
        drv_ready = 1'b1;
        send(16'h0009, 1'b1, 1'b0);
        res("t6.final", 16'h0009, 16'hFFF6, 1'b0, 8'd1, 2'd1, 1'b0);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
